// File: rtl/fa_vector_if.sv
// fa_vector_if: stimulus/response bundle between a full-adder checker and the adder under test
interface fa_vector_if;
   logic a, b, cin, sum, cout;
   modport master (output a, b, cin, input sum, cout);
   modport slave (input a, b, cin, output sum, cout);
endinterface

// File: rtl/fa_vector_checker.sv
// fa_vector_checker: drives all 8 full-adder vectors, samples after a settle time and reports errors
module fa_vector_checker #(
   parameter int SETTLE_CYCLES = 4,
   parameter int ERR_W = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   fa_vector_if.master vec,
   output logic busy,
   output logic done,
   output logic pass,
   output logic [ERR_W-1:0] err_count,
   output logic [2:0] first_fail_vec,
   output logic first_fail_valid
);
   typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("fa_vector_checker: SETTLE_CYCLES must be in 1..15");
   end
   state_t state_q, state_d;
   logic [2:0] idx;
   logic [3:0] cnt;
   logic go, last, fail, gs, gc;
   always_comb begin
      go = start && state_q != DRIVE;
      last = state_q == DRIVE && cnt == 4'(SETTLE_CYCLES - 1);
      gs = ^idx;
      gc = (idx[2] & idx[1]) | (idx[2] & idx[0]) | (idx[1] & idx[0]);
      fail = vec.sum != gs || vec.cout != gc;
      state_d = go ? DRIVE : (last && idx == 3'd7) ? DONE : state_q;
   end
   // idx doubles as the registered stimulus; it parks at 7 in DONE
   assign vec.a = idx[2];
   assign vec.b = idx[1];
   assign vec.cin = idx[0];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx <= '0;
         cnt <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         pass <= 1'b0;
         err_count <= '0;
         first_fail_vec <= '0;
         first_fail_valid <= 1'b0;
      end else begin
         state_q <= state_d;
         if (go) begin
            idx <= '0;
            cnt <= '0;
            busy <= 1'b1;
            done <= 1'b0;
            pass <= 1'b0;
            err_count <= '0;
            first_fail_vec <= '0;
            first_fail_valid <= 1'b0;
         end else if (last) begin
            if (fail) begin
               err_count <= &err_count ? err_count : err_count + 1'b1;
               if (!first_fail_valid) begin
                  first_fail_vec <= idx;
                  first_fail_valid <= 1'b1;
               end
            end
            cnt <= '0;
            if (idx == 3'd7) begin
               busy <= 1'b0;
               done <= 1'b1;
               pass <= err_count == '0 && !fail;
            end else
               idx <= idx + 1'b1;
         end else if (state_q == DRIVE)
            cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_fa_vector_checker.sv
// tb_fa_vector_checker: three checker instances against a fault-injectable full adder and a run-level model
module tb_fa_vector_checker;
   localparam int SS[3] = '{4, 4, 1};
   localparam int EMAX[3] = '{15, 3, 15};
   logic clk, rst_n;
   logic [2:0] start, busy, done, pass, ffv;
   logic [2:0][2:0] ffvec, vecv;
   logic [2:0][3:0] ec;
   logic s0;
   logic [7:0] smask, cmask;
   int total = 0, bad = 0;
   int st[3], t[3];
   logic [7:0] ef[3];
   int c;
   fa_vector_if vi0 ();
   fa_vector_if vi1 ();
   fa_vector_if vi2 ();
   // adder under test: s0 forces sum low, masks flip individual vector responses
   assign vi0.sum = s0 ? 1'b0 : (vi0.a ^ vi0.b ^ vi0.cin) ^ smask[{vi0.a, vi0.b, vi0.cin}];
   assign vi0.cout = ((vi0.a & vi0.b) | (vi0.a & vi0.cin) | (vi0.b & vi0.cin)) ^ cmask[{vi0.a, vi0.b, vi0.cin}];
   assign vi1.sum = s0 ? 1'b0 : (vi1.a ^ vi1.b ^ vi1.cin) ^ smask[{vi1.a, vi1.b, vi1.cin}];
   assign vi1.cout = ((vi1.a & vi1.b) | (vi1.a & vi1.cin) | (vi1.b & vi1.cin)) ^ cmask[{vi1.a, vi1.b, vi1.cin}];
   assign vi2.sum = s0 ? 1'b0 : (vi2.a ^ vi2.b ^ vi2.cin) ^ smask[{vi2.a, vi2.b, vi2.cin}];
   assign vi2.cout = ((vi2.a & vi2.b) | (vi2.a & vi2.cin) | (vi2.b & vi2.cin)) ^ cmask[{vi2.a, vi2.b, vi2.cin}];
   assign vecv[0] = {vi0.a, vi0.b, vi0.cin};
   assign vecv[1] = {vi1.a, vi1.b, vi1.cin};
   assign vecv[2] = {vi2.a, vi2.b, vi2.cin};
   assign ec[1][3:2] = 2'b0;
   fa_vector_checker #(.SETTLE_CYCLES(4), .ERR_W(4)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .vec(vi0), .busy(busy[0]), .done(done[0]),
      .pass(pass[0]), .err_count(ec[0]), .first_fail_vec(ffvec[0]), .first_fail_valid(ffv[0]));
   fa_vector_checker #(.SETTLE_CYCLES(4), .ERR_W(2)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .vec(vi1), .busy(busy[1]), .done(done[1]),
      .pass(pass[1]), .err_count(ec[1][1:0]), .first_fail_vec(ffvec[1]), .first_fail_valid(ffv[1]));
   fa_vector_checker #(.SETTLE_CYCLES(1), .ERR_W(4)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start[2]), .vec(vi2), .busy(busy[2]), .done(done[2]),
      .pass(pass[2]), .err_count(ec[2]), .first_fail_vec(ffvec[2]), .first_fail_valid(ffv[2]));
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   function automatic bit fails(input int v);
      int s = v % 2 + (v / 2) % 2 + v / 4;
      int so = s0 ? 0 : (s % 2) ^ int'(smask[v]);
      int co = int'(s >= 2) ^ int'(cmask[v]);
      return so != s % 2 || co != int'(s >= 2);
   endfunction
   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask
   // run-level model: cycles since the start edge decide vector, flags and results
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         for (int i = 0; i < 3; i++) st[i] <= 0;
      else
         for (int i = 0; i < 3; i++)
            if (st[i] != 1 && start[i]) begin
               st[i] <= 1;
               t[i] <= 0;
               for (int v = 0; v < 8; v++) ef[i][v] <= fails(v);
            end else if (st[i] == 1) begin
               t[i] <= t[i] + 1;
               if (t[i] + 1 == 8 * SS[i]) st[i] <= 2;
            end
   end
   always @(negedge clk) begin
      int n, nf, ff;
      for (int i = 0; i < 3; i++) begin
         n = st[i] == 1 ? t[i] / SS[i] : st[i] == 2 ? 8 : 0;
         nf = 0;
         ff = -1;
         for (int v = 0; v < 8; v++)
            if (v < n && ef[i][v]) begin
               nf++;
               if (ff < 0) ff = v;
            end
         chk($sformatf("busy%0d", i), int'(busy[i]), int'(st[i] == 1));
         chk($sformatf("done%0d", i), int'(done[i]), int'(st[i] == 2));
         chk($sformatf("pass%0d", i), int'(pass[i]), int'(st[i] == 2 && nf == 0));
         chk($sformatf("vec%0d", i), int'(vecv[i]), st[i] == 1 ? t[i] / SS[i] : st[i] == 2 ? 7 : 0);
         chk($sformatf("err_count%0d", i), int'(ec[i]), nf > EMAX[i] ? EMAX[i] : nf);
         chk($sformatf("ff_valid%0d", i), int'(ffv[i]), int'(ff >= 0));
         chk($sformatf("ff_vec%0d", i), int'(ffvec[i]), ff >= 0 ? ff : 0);
      end
   end
   task automatic pulse(input int i);
      @(negedge clk);
      start[i] = 1'b1;
      @(negedge clk);
      start[i] = 1'b0;
   endtask
   task automatic run(input int i, output int cyc);
      pulse(i);
      cyc = 0;
      while (!done[i] && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
   endtask
   initial begin
      rst_n = 1'b0;
      start = '0;
      s0 = 1'b0;
      smask = '0;
      cmask = '0;
      #3;
      chk("rst_busy", int'(busy[0]), 0);
      chk("rst_done", int'(done[0]), 0);
      chk("rst_err", int'(ec[0]), 0);
      chk("rst_vec", int'(vecv[0]), 0);
      @(negedge clk);
      rst_n = 1'b1;
      run(0, c);
      chk("lat_s4", c, 32);
      chk("good_err", int'(ec[0]), 0);
      chk("good_pass", int'(pass[0]), 1);
      chk("good_ffv", int'(ffv[0]), 0);
      s0 = 1'b1;
      run(0, c);
      chk("s0_err", int'(ec[0]), 4);
      chk("s0_pass", int'(pass[0]), 0);
      chk("s0_ffvec", int'(ffvec[0]), 1);
      chk("s0_ffv", int'(ffv[0]), 1);
      s0 = 1'b0;
      run(0, c);
      chk("rerun_err", int'(ec[0]), 0);
      chk("rerun_pass", int'(pass[0]), 1);
      chk("rerun_ffv", int'(ffv[0]), 0);
      cmask = 8'hff;
      run(0, c);
      chk("inv_err", int'(ec[0]), 8);
      chk("inv_ffvec", int'(ffvec[0]), 0);
      run(1, c);
      chk("sat_err", int'(ec[1]), 3);
      cmask = 8'h00;
      run(2, c);
      chk("lat_s1", c, 8);
      chk("s1_pass", int'(pass[2]), 1);
      smask = 8'h20;
      pulse(0);
      repeat (12) @(negedge clk);
      chk("mid_vec3", int'(vecv[0]), 3);
      pulse(0);
      c = 0;
      while (vecv[0] != 3'd5 && c < 100) begin
         @(negedge clk);
         c++;
      end
      chk("reach_vec5", int'(vecv[0]), 5);
      chk("still_busy", int'(busy[0]), 1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", int'(busy[0]), 0);
      chk("arst_vec", int'(vecv[0]), 0);
      chk("arst_done", int'(done[0]), 0);
      chk("arst_err", int'(ec[0]), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      smask = 8'h00;
      run(0, c);
      chk("post_rst_lat", c, 32);
      chk("post_rst_pass", int'(pass[0]), 1);
      for (int r = 0; r < 12; r++) begin
         int i = $urandom_range(0, 2);
         s0 = $urandom_range(0, 3) == 0;
         smask = $urandom_range(0, 2) == 0 ? 8'h00 : 8'($urandom);
         cmask = $urandom_range(0, 2) == 0 ? 8'h00 : 8'($urandom);
         run(i, c);
         chk("rand_lat", c, 8 * SS[i]);
      end
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule

// File: doc/fa_vector_checker.md
Name: fa_vector_checker

Overview:
Synthesizable exhaustive stimulus sequencer and response checker for a 1-bit full adder.
- Drives all 8 input combinations onto the DUT.
- Waits a programmable settle time per vector, then samples the DUT outputs and compares them against the golden sum/carry.
- Reports error count, first failing vector and pass/fail.
- Sits beside any full-adder implementation (primitive, AOI-based, dataflow) as the on-chip self-check end of the vector interface.

Parameters:
SETTLE_CYCLES, 4, clock cycles each vector is held before sampling; legal 1..15
ERR_W, 4, width of the error counter; counter saturates at 2^ERR_W-1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a check run; sampled only in IDLE or DONE
a  output  1  DUT operand a (registered)
b  output  1  DUT operand b (registered)
cin  output  1  DUT carry-in (registered)
sum  input  1  DUT sum response
cout  input  1  DUT carry-out response
busy  output  1  high while vectors are being applied
done  output  1  high from run completion until next start or reset
pass  output  1  valid when done=1; 1 iff err_count==0
err_count  output  ERR_W  number of failing vectors in the last run
first_fail_vec  output  3  index {a,b,cin} of the first failing vector
first_fail_valid  output  1  first_fail_vec holds a captured failure

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (async, any state including mid-run):
  - state=IDLE.
  - a, b, cin, busy, done, pass, first_fail_valid = 0.
  - err_count = 0, first_fail_vec = 0.
  - Internal vector index and settle counter = 0.
- State IDLE:
  - start=1 at edge k -> DRIVE.
  - Index=0, so {a,b,cin}=3'b000 is visible after edge k.
  - busy=1; err_count, first_fail_* and pass are cleared.
- State DRIVE:
  - {a,b,cin} = index, with a=index[2], b=index[1], cin=index[0].
  - Settle counter counts 0..SETTLE_CYCLES-1.
  - On the edge where counter==SETTLE_CYCLES-1: sample sum/cout and compare against the golden values.
    - Golden sum = a^b^cin.
    - Golden cout = (a&b)|(a&cin)|(b&cin).
    - A mismatch on either bit counts as one failing vector.
    - Failing vector: err_count increments, saturating at all-ones. If first_fail_valid==0, capture first_fail_vec=index and set first_fail_valid=1.
    - Then, if index<7: index increments and the counter returns to 0.
    - If index==7: go to DONE.
- Timing: comparisons occur at edges k+S, k+2S, ..., k+8S (S=SETTLE_CYCLES). Run latency from the start edge to done=1 is exactly 8*S cycles.
- State DONE:
  - busy=0, done=1.
  - pass = (err_count==0), registered on the DONE-entry edge.
  - a, b, cin hold 3'b111.
  - start=1 -> restart exactly as from IDLE, clearing done/pass/err_count/first_fail_*.
- start is ignored while busy=1. No abort except reset.
- start and DONE entry on the same edge cannot occur, because start is ignored in DRIVE.
- Outputs a, b, cin, busy, done, pass, err_count and first_fail_* are all registered; there are no combinational paths from inputs to outputs.
- Out-of-range SETTLE_CYCLES is illegal; the implementation must not wrap the counter silently. Enforce the range with an elaboration-time check.

Test Plan:
1. Correct behavioural full adder as DUT, S=4: pulse start -> busy=1 for 32 cycles; done=1 on edge k+32; err_count=0; pass=1; first_fail_valid=0; a/b/cin step 000..111 every 4 cycles.
2. sum stuck-at-0 DUT -> err_count=4, pass=0, first_fail_vec=3'b001, first_fail_valid=1.
3. Inverted cout DUT -> all 8 vectors fail: err_count=8 (ERR_W=4), first_fail_vec=3'b000. Repeat with ERR_W=2 -> err_count saturates at 3.
4. Pulse start again during vector 3, then assert rst_n=0 mid-run at vector 5:
   - Second start is ignored and the run continues.
   - On reset, all outputs go to 0 immediately (asynchronously) and state=IDLE.
   - A fresh start after reset completes normally.
5. From DONE after failing run 2, swap in the correct DUT and pulse start -> done drops the next edge; the new run reports err_count=0, pass=1, first_fail_valid=0.
6. S=1 with the correct DUT -> done at edge k+8; each vector is held exactly 1 cycle; pass=1.
